// File: rtl/mode_switch_ctrl_pkg.sv
// Shared types and defaults for the mode switch controller: FSM state encoding,
// default window lengths and the counter sizing rule.
package mode_switch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUIESCE = 3'd1,
    SWITCH  = 3'd2,
    SETTLE  = 3'd3,
    ACK     = 3'd4
  } state_t;

  localparam int DEFAULT_HOLD_CYCLES   = 4;
  localparam int DEFAULT_SETTLE_CYCLES = 3;

  // Counters must hold the larger of the two windows without wrapping.
  function automatic int cnt_width(input int hold, input int settle);
    return $clog2(((hold > settle) ? hold : settle) + 1);
  endfunction

endpackage

// File: rtl/mode_switch_ctrl_sel_stable_cnt.sv
// Registers sel and counts consecutive cycles in which it has not changed;
// the count saturates at SAT and restarts on any change or on clr.
module sel_stable_cnt
  import mode_switch_ctrl_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int SAT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sel,
  output logic             stable,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] SAT_VAL = WIDTH'(SAT);

  logic sel_q;

  assign stable = (sel == sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= 1'b0;
      count <= '0;
    end else begin
      sel_q <= sel;
      if (clr || !stable) begin
        count <= '0;
      end else if (count != SAT_VAL) begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mode_switch_ctrl.sv
// Arbitrates two mode-change requesters and sequences the select cell's mode pin,
// switching only after sel has been quiet and freezing sel while the new mode settles.
module mode_switch_ctrl
  import mode_switch_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] req_mode,
  input  logic       sel,
  output logic       mode,
  output logic       sel_hold,
  output logic [1:0] ack,
  output logic       busy,
  output logic       err
);

  localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CW      = cnt_width(HOLD_CYCLES, SETTLE_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  state_t        state, state_nx;
  logic          g, g_nx;
  logic          t, t_nx;
  logic          lp;
  logic          clr_stable;
  logic          stable;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] settle_cnt;

  sel_stable_cnt #(
    .WIDTH(CW),
    .SAT  (CNT_MAX)
  ) u_stable (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_stable),
    .sel   (sel),
    .stable(stable),
    .count (stable_cnt)
  );

  always_comb begin
    state_nx   = state;
    g_nx       = g;
    t_nx       = t;
    clr_stable = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          // The requester that was not served last wins whenever it is asking.
          g_nx = req[~lp] ? ~lp : lp;
          t_nx = req_mode[g_nx];
          if (t_nx == mode) begin
            state_nx = ACK;
          end else begin
            state_nx   = QUIESCE;
            clr_stable = 1'b1;
          end
        end
      end
      QUIESCE: if (stable && stable_cnt == HOLD_LAST) state_nx = SWITCH;
      SWITCH:  state_nx = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      g          <= 1'b0;
      t          <= 1'b0;
      lp         <= 1'b1;
      settle_cnt <= '0;
      mode       <= 1'b0;
      sel_hold   <= 1'b0;
      ack        <= 2'b00;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state    <= state_nx;
      g        <= g_nx;
      t        <= t_nx;
      sel_hold <= state_nx inside {QUIESCE, SWITCH, SETTLE};
      busy     <= (state_nx != IDLE);
      ack      <= (state_nx == ACK) ? (g_nx ? 2'b10 : 2'b01) : 2'b00;
      if (state == ACK) lp <= g;
      if (state == SWITCH) begin
        mode       <= t;
        settle_cnt <= '0;
      end else if (state == SETTLE && settle_cnt != SETTLE_LAST) begin
        settle_cnt <= settle_cnt + CW'(1);
      end
      if (state == SETTLE && !stable) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Randomized scoreboard bench for mode_switch_ctrl: a transaction-level model predicts
// each ack (value, cycle, mode, err); a monitor pops predictions whenever ack fires.
module tb_mode_switch_ctrl;

  localparam int HOLD   = 4;
  localparam int SETTLE = 3;

  typedef struct {
    logic [1:0] ack_v;
    int         cyc;
    logic       mode_v;
    logic       err_v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] req_mode;
  logic       sel;
  logic       mode;
  logic       sel_hold;
  logic [1:0] ack;
  logic       busy;
  logic       err;

  int   cyc     = 0;
  int   vectors = 0;
  int   fails   = 0;
  exp_t sb[$];

  // Reference model state kept at transaction granularity.
  int   lp_m;
  logic mode_m;
  logic err_m;
  logic sel_cur;

  mode_switch_ctrl #(
    .HOLD_CYCLES  (HOLD),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_mode(req_mode),
    .sel     (sel),
    .mode    (mode),
    .sel_hold(sel_hold),
    .ack     (ack),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, actual, required);
    end
  endtask

  // Monitor: every ack pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    exp_t e;
    if (ack !== 2'b00) begin
      if (sb.size() == 0) begin
        vectors++;
        fails++;
        $display("[TB] FAIL unexpected_ack cycle=%0d actual=%b required=none", cyc, ack);
      end else begin
        e = sb.pop_front();
        check_output("ack_value", 32'(ack), 32'(e.ack_v));
        check_output("ack_cycle", 32'(cyc), 32'(e.cyc));
        check_output("ack_mode", 32'(mode), 32'(e.mode_v));
        check_output("ack_err", 32'(err), 32'(e.err_v));
      end
    end
  end

  task automatic check_quiet(input logic exp_mode);
    check_output("mode", 32'(mode), 32'(exp_mode));
    check_output("sel_hold", 32'(sel_hold), 32'(0));
    check_output("busy", 32'(busy), 32'(0));
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet(1'b0);
    check_output("reset_ack", 32'(ack), 32'(0));
    check_output("reset_err", 32'(err), 32'(0));
    lp_m   = 1;
    mode_m = 1'b0;
    err_m  = 1'b0;
    sb.delete();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      req     = 2'b00;
      sel_cur = sel_cur ^ 1'($urandom_range(0, 1));
      sel     = sel_cur;
      @(negedge clk);
      check_quiet(mode_m);
    end
  endtask

  // One granted sequence, starting at an IDLE cycle (rel 0) with request pattern rq.
  task automatic apply_stimulus(input logic [1:0] rq, input logic [1:0] rm, input int q_pct,
                                input logic [31:0] force_tog, input int s_pct,
                                input int rst_at_in, input bit drop_early,
                                output bit interrupted);
    int   w, q, ack_rel, run, ntog, j, rst_at, base;
    logic tgt, tog, switching, err_next, exp_mode, exp_hold;
    logic [1:0] req_drv;
    logic seq [0:255];
    exp_t e;

    w         = rq[1 - lp_m] ? (1 - lp_m) : lp_m;
    tgt       = rm[w];
    switching = (tgt != mode_m);
    err_next  = err_m;
    seq[0]    = sel_cur;
    q         = 0;
    if (switching) begin
      // Needs HOLD unchanged cycles in a row after entering; any toggle restarts the run.
      run  = 0;
      ntog = 0;
      j    = 0;
      while (run < HOLD) begin
        j++;
        tog = 1'b0;
        if (j < 32 && force_tog[j]) tog = 1'b1;
        if (ntog < 8 && $urandom_range(0, 99) < q_pct) tog = 1'b1;
        if (tog) ntog++;
        seq[j] = seq[j-1] ^ tog;
        run    = tog ? 0 : run + 1;
      end
      q          = j;
      seq[q + 1] = seq[q];
      for (int k = q + 2; k <= q + SETTLE + 1; k++) begin
        tog    = 1'($urandom_range(0, 99) < s_pct);
        seq[k] = seq[k-1] ^ tog;
        if (tog) err_next = 1'b1;
      end
      ack_rel          = q + SETTLE + 2;
      seq[ack_rel]     = seq[ack_rel - 1];
    end else begin
      ack_rel = 1;
      seq[1]  = seq[0];
    end

    rst_at      = (rst_at_in >= ack_rel) ? -1 : rst_at_in;
    interrupted = (rst_at >= 0);

    for (int rel = 0; rel <= ack_rel; rel++) begin
      @(posedge clk);
      #1;
      if (rel == 0) begin
        base = cyc;
        if (!interrupted) begin
          e.ack_v  = (w == 1) ? 2'b10 : 2'b01;
          e.cyc    = base + ack_rel;
          e.mode_v = tgt;
          e.err_v  = err_next;
          sb.push_back(e);
        end
      end
      req_drv = rq;
      if (drop_early && rel >= 2) req_drv[w] = 1'b0;
      req      = req_drv;
      req_mode = rm;
      sel      = seq[rel];
      rst      = (rel == rst_at);
      @(negedge clk);
      exp_mode = (switching && rel >= q + 2) ? tgt : mode_m;
      exp_hold = switching && rel >= 1 && rel <= q + SETTLE + 1;
      check_output("mode", 32'(mode), 32'(exp_mode));
      check_output("sel_hold", 32'(sel_hold), 32'(exp_hold));
      check_output("busy", 32'(busy), 32'(rel >= 1));
      if (rel == rst_at) begin
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 2'b00;
        @(negedge clk);
        check_quiet(1'b0);
        check_output("rst_ack", 32'(ack), 32'(0));
        check_output("rst_err", 32'(err), 32'(0));
        lp_m    = 1;
        mode_m  = 1'b0;
        err_m   = 1'b0;
        sel_cur = seq[rel];
        return;
      end
    end
    if (switching) mode_m = tgt;
    err_m   = err_next;
    lp_m    = w;
    sel_cur = seq[ack_rel];
  endtask

  initial begin
    bit         intr;
    logic [1:0] rq, rm, loser;
    int         ra;

    rst      = 1'b1;
    req      = 2'b00;
    req_mode = 2'b00;
    sel      = 1'b0;
    sel_cur  = 1'b0;
    lp_m     = 1;
    mode_m   = 1'b0;
    err_m    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet(1'b0);
    check_output("reset_ack", 32'(ack), 32'(0));
    check_output("reset_err", 32'(err), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] directed sequences");
    apply_stimulus(2'b01, 2'b01, 0, 32'h0, 0, -1, 1'b0, intr);
    apply_stimulus(2'b10, 2'b10, 0, 32'h0, 0, -1, 1'b0, intr);
    apply_reset();
    apply_stimulus(2'b11, 2'b10, 0, 32'h0, 0, -1, 1'b0, intr);
    apply_stimulus(2'b10, 2'b10, 0, 32'h0, 0, -1, 1'b0, intr);
    apply_stimulus(2'b11, 2'b01, 0, 32'h0, 0, -1, 1'b0, intr);
    apply_stimulus(2'b10, 2'b01, 0, 32'h0, 0, -1, 1'b0, intr);
    apply_stimulus(2'b01, 2'b01, 0, 32'h0000_000C, 0, -1, 1'b0, intr);
    apply_stimulus(2'b10, 2'b00, 0, 32'h0, 100, -1, 1'b1, intr);
    idle_cycles(2);
    apply_stimulus(2'b01, 2'b00, 0, 32'h0, 0, -1, 1'b0, intr);
    apply_reset();
    apply_stimulus(2'b01, 2'b11, 0, 32'h0, 0, 7, 1'b0, intr);

    $display("[TB] randomized sequences");
    for (int n = 0; n < 40; n++) begin
      rq = 2'($urandom_range(1, 3));
      rm = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 6)) : -1;
      apply_stimulus(rq, rm, int'($urandom_range(0, 30)), 32'h0,
                     ($urandom_range(0, 3) == 0) ? 25 : 0, ra,
                     1'($urandom_range(0, 1)), intr);
      if (!intr && rq == 2'b11) begin
        loser = (lp_m == 0) ? 2'b10 : 2'b01;
        apply_stimulus(loser, rm, int'($urandom_range(0, 30)), 32'h0, 0, -1,
                       1'($urandom_range(0, 1)), intr);
      end
      idle_cycles(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) apply_reset();
    end

    idle_cycles(3);
    check_output("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
